// File: rtl/arith_op_sequencer.sv
// Issue/capture sequencer for the 4-bit arithmetic/compare unit.
//
// A command (in_a, in_b, in_op) is accepted over a valid/ready handshake and
// latched into registered, stable operands for the external combinational unit.
// After SETTLE_CYCLES extra cycles the unit's result and flags are captured,
// checked for consistency, and offered downstream over valid/ready.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready         command handshake
//   in_a, in_b, in_op         command operands and op (0 add, 1 sub, 2 cmp, 3 reserved)
//   alu_a, alu_b, alu_ctrl    registered operands/op driven to the unit
//   alu_result, alu_flag      unit result and {gt,eq,lt} flags
//   out_valid/out_ready       result handshake
//   out_result, out_flag      captured result and flags
//   out_op, out_err           op that produced the result, error indication
//   busy                      high whenever not idle
//   op_count                  results consumed downstream, wraps modulo 2^COUNT_W

module arith_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_a,
  input  logic [3:0]         in_b,
  input  logic [1:0]         in_op,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [1:0]         alu_ctrl,
  input  logic [3:0]         alu_result,
  input  logic [2:0]         alu_flag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_result,
  output logic [2:0]         out_flag,
  output logic [1:0]         out_op,
  output logic               out_err,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StOut  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                busy_q;
  logic [3:0]          alu_a_q, alu_b_q;
  logic [1:0]          alu_ctrl_q;
  logic [3:0]          out_result_q;
  logic [2:0]          out_flag_q;
  logic [1:0]          out_op_q;
  logic                out_err_q;
  logic [COUNT_W-1:0]  op_count_q;

  logic accept, capture, retire;
  logic flag_onehot, capt_err;

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StOut;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          retire  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A compare result must mirror its flags, and flags must always be one-hot.
  always_comb begin
    flag_onehot = (alu_flag == 3'b100) || (alu_flag == 3'b010) || (alu_flag == 3'b001);
    capt_err    = (alu_ctrl_q == 2'd3) ||
                  ((alu_ctrl_q == 2'd2) && (alu_result != {1'b0, alu_flag})) ||
                  !flag_onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  // Operands only ever change on an accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
    end else if (accept) begin
      alu_a_q    <= in_a;
      alu_b_q    <= in_b;
      alu_ctrl_q <= in_op;
    end
  end

  // Captured outputs hold their value after retire until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result_q <= '0;
      out_flag_q   <= '0;
      out_op_q     <= '0;
      out_err_q    <= 1'b0;
    end else if (capture) begin
      out_result_q <= alu_result;
      out_flag_q   <= alu_flag;
      out_op_q     <= alu_ctrl_q;
      out_err_q    <= capt_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (retire) begin
      op_count_q <= op_count_q + COUNT_W'(1);
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StOut);
  assign busy       = busy_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign out_result = out_result_q;
  assign out_flag   = out_flag_q;
  assign out_op     = out_op_q;
  assign out_err    = out_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Bench for arith_op_sequencer: directed commands, an in-bench arithmetic unit,
// a transaction-level model compared every cycle, and literal spot checks.

module tb_arith_op_sequencer;

  localparam int unsigned Settle = 1;
  localparam int unsigned CountW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_a = '0;
  logic [3:0]        in_b = '0;
  logic [1:0]        in_op = '0;
  logic [3:0]        alu_a, alu_b;
  logic [1:0]        alu_ctrl;
  logic [3:0]        alu_result;
  logic [2:0]        alu_flag;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        out_result;
  logic [2:0]        out_flag;
  logic [1:0]        out_op;
  logic              out_err;
  logic              busy;
  logic [CountW-1:0] op_count;

  logic              force_en = 1'b0;
  logic [3:0]        force_val = '0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  arith_op_sequencer #(
    .SETTLE_CYCLES(Settle),
    .COUNT_W      (CountW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result),
    .alu_flag  (alu_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flag  (out_flag),
    .out_op    (out_op),
    .out_err   (out_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Stand-in for the external unit: flags are always the A-vs-B comparison.
  function automatic logic [2:0] cmp_flag(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [3:0] unit_result(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op, input logic fe,
                                             input logic [3:0] fv);
    logic [3:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = {1'b0, cmp_flag(a, b)};
      default: r = 4'd0;
    endcase
    if (fe) r = fv;
    return r;
  endfunction

  always_comb begin
    alu_flag   = cmp_flag(alu_a, alu_b);
    alu_result = unit_result(alu_a, alu_b, alu_ctrl, force_en, force_val);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: one pending command, captured after Settle+1 edges.
  bit         m_busy, m_valid, m_err;
  logic [3:0] m_a, m_b, m_res;
  logic [1:0] m_ctrl, m_op;
  logic [2:0] m_flag;
  int         m_count, m_edges;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_valid = 0; m_err = 0; m_a = 0; m_b = 0; m_ctrl = 0;
        m_res = 0; m_flag = 0; m_op = 0; m_count = 0; m_edges = 0;
      end
      if (chk_en) begin
        check("in_ready", in_ready, !m_busy);
        check("busy", busy, m_busy);
        check("out_valid", out_valid, m_valid);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_ctrl", alu_ctrl, m_ctrl);
        check("out_result", out_result, m_res);
        check("out_flag", out_flag, m_flag);
        check("out_op", out_op, m_op);
        check("out_err", out_err, m_err);
        check("op_count", op_count, m_count);
      end
      // Predict the effect of the coming rising edge.
      if (!rst) begin
        if (!m_busy) begin
          if (in_valid) begin
            m_a = in_a; m_b = in_b; m_ctrl = in_op;
            m_busy = 1; m_edges = Settle + 1;
          end
        end else if (!m_valid) begin
          m_edges--;
          if (m_edges == 0) begin
            m_flag  = cmp_flag(m_a, m_b);
            m_res   = unit_result(m_a, m_b, m_ctrl, force_en, force_val);
            m_op    = m_ctrl;
            m_err   = (m_ctrl == 2'd3) || ((m_ctrl == 2'd2) && (m_res != {1'b0, m_flag})) ||
                      ($countones(m_flag) != 1);
            m_valid = 1;
          end
        end else if (out_ready) begin
          m_count = (m_count + 1) % (1 << CountW);
          m_valid = 0;
          m_busy  = 0;
        end
      end
    end
  end

  // Issue one command from idle, wait for the result, then retire it.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        output logic [3:0] r, output logic [2:0] f, output logic e,
                        output int lat, output int cnt);
    in_valid = 1; in_a = a; in_b = b; in_op = op; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out_result; f = out_flag; e = out_err;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    cnt = int'(op_count);
  endtask

  logic [3:0] r;
  logic [2:0] f;
  logic       e;
  int         lat, cnt, wait_n;

  typedef struct {
    logic [3:0] a, b;
    logic [1:0] op;
    logic [3:0] r;
    logic [2:0] f;
    int         cnt;
  } vec_t;

  vec_t wrap_vecs[5] = '{
    '{a: 4'd1,  b: 4'd2, op: 2'd0, r: 4'd3,  f: 3'b001, cnt: 1},
    '{a: 4'd6,  b: 4'd6, op: 2'd2, r: 4'd2,  f: 3'b010, cnt: 2},
    '{a: 4'd15, b: 4'd1, op: 2'd0, r: 4'd0,  f: 3'b100, cnt: 3},
    '{a: 4'd0,  b: 4'd1, op: 2'd1, r: 4'hF,  f: 3'b001, cnt: 0},
    '{a: 4'd8,  b: 4'd8, op: 2'd1, r: 4'd0,  f: 3'b010, cnt: 1}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_op_count", op_count, 0);
    rst = 0;
    chk_en = 1;

    // Add: 5+3
    run_op(4'd5, 4'd3, 2'd0, r, f, e, lat, cnt);
    check("add_latency", lat, 2);
    check("add_result", r, 4'd8);
    check("add_flag", f, 3'b100);
    check("add_err", e, 0);
    check("add_count", cnt, 1);

    // Subtract wrap: 3-5
    run_op(4'd3, 4'd5, 2'd1, r, f, e, lat, cnt);
    check("sub_result", r, 4'hE);
    check("sub_flag", f, 3'b001);
    check("sub_err", e, 0);

    // Compare equal
    run_op(4'd7, 4'd7, 2'd2, r, f, e, lat, cnt);
    check("cmp_result", r, 4'b0010);
    check("cmp_flag", f, 3'b010);
    check("cmp_err", e, 0);

    // Compare with inconsistent result from a bypassed unit
    force_en = 1; force_val = 4'b0100;
    run_op(4'd7, 4'd7, 2'd2, r, f, e, lat, cnt);
    force_en = 0;
    check("cmpbad_result", r, 4'b0100);
    check("cmpbad_err", e, 1);
    check("cmpbad_count", cnt, 0);

    // Reserved op held under backpressure; a stray command must be ignored
    in_valid = 1; in_a = 4'd9; in_b = 4'd2; in_op = 2'd3;
    @(posedge clk); #1;
    in_valid = 0;
    wait_n = 0;
    while (!out_valid && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("rsv_latency", wait_n, 2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin in_valid = 1; in_a = 4'd1; in_b = 4'd1; in_op = 2'd0; end
      if (i == 4) in_valid = 0;
      check("rsv_hold_valid", out_valid, 1);
      check("rsv_hold_ready", in_ready, 0);
      check("rsv_hold_result", out_result, 4'd0);
      check("rsv_hold_err", out_err, 1);
      check("rsv_hold_op", out_op, 2'd3);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("rsv_count", op_count, 1);
    check("rsv_after_valid", out_valid, 0);
    check("rsv_after_err", out_err, 1);

    // Reset while waiting for the unit to settle
    in_valid = 1; in_a = 4'd4; in_b = 4'd4; in_op = 2'd0;
    @(posedge clk); #1;
    in_valid = 0;
    check("mid_busy", busy, 1);
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_ctrl", alu_ctrl, 0);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_err", out_err, 0);
    @(posedge clk); #1;
    rst = 0;
    check("post_rst_ready", in_ready, 1);

    // Counter wrap over five retirements
    foreach (wrap_vecs[i]) begin
      run_op(wrap_vecs[i].a, wrap_vecs[i].b, wrap_vecs[i].op, r, f, e, lat, cnt);
      check("wrap_latency", lat, 2);
      check("wrap_result", r, wrap_vecs[i].r);
      check("wrap_flag", f, wrap_vecs[i].f);
      check("wrap_err", e, 0);
      check("wrap_count", cnt, wrap_vecs[i].cnt);
    end

    repeat (2) @(posedge clk);
    #1;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
